fc_in_deserializer: RTL and testbench
=====================================

// Module: fc_in_deserializer
// PURPOSE
//  Upstream stage of the fully-connected neuron layer. Collects a serial valid/ready
//  stream of WIDTH-bit activations into an IN-entry register bank and presents it as
//  the parallel x[0:IN-1] vector that the combinational booth/add2/relu layer consumes.
//  Holds x stable while out_valid is high, until the consumer accepts the frame.
// PARAMETERS
//  WIDTH  8    activation bit width; must match the layer WIDTH
//  IN     128  activations per frame; must match the layer IN (>=2)
// PORTS
//  clk        in   1                    rising-edge clock
//  rst_n      in   1                    asynchronous active-low reset
//  s_valid    in   1                    input beat valid
//  s_ready    out  1                    input beat accepted when s_valid&&s_ready
//  s_data     in   WIDTH                activation value, signed two's complement
//  s_last     in   1                    final beat of the frame
//  x          out  WIDTH x [0:IN-1]     parallel activation vector to layer
//  out_valid  out  1                    x holds a complete frame
//  out_ready  in   1                    consumer has sampled the layer output
//  err_short  out  1                    1-cycle pulse: s_last before beat IN-1
//  err_long   out  1                    1-cycle pulse: beat IN-1 without s_last
// BEHAVIOUR
//  - One clock domain. Reset is asynchronous and active-low. rst_n=0 forces state=FILL,
//    cnt=0, every x[i]=0, out_valid=0, err_short=0, err_long=0. s_ready is 1 after reset.
//  - cnt is $clog2(IN) bits and holds the index of the next write.
//  - State FILL: s_ready=1, out_valid=0. On accept, x[cnt]<=s_data and cnt<=cnt+1.
//    . Accept with cnt==IN-1: go to FULL, cnt<=0. If s_last=0, err_long pulses next cycle.
//    . Accept with s_last=1 and cnt<IN-1: go to FULL, cnt<=0, err_short pulses next
//      cycle. Unwritten entries keep 0 (cleared on FULL exit).
//  - State FULL: s_ready=0, out_valid=1. x is frozen. s_valid is ignored and no beat
//    is accepted.
//    . out_valid&&out_ready: go to FILL, all x[i]<=0, cnt=0. s_ready=1 from the next cycle.
//  - Latency: out_valid rises 1 cycle after the final-beat accept. Throughput is IN+1
//    cycles per frame at full rate (single buffer, no FILL/FULL overlap).
//  - x is a straight register copy with no arithmetic. Sign is preserved bit-exact.
//  - s_ready depends only on state (no combinational path from out_ready).
//  - The error pulses are informational only. Data is still delivered, and the next
//    frame starts at index 0.
//  - Reset asserted mid-frame or in FULL discards the partial or held frame immediately
//    with no pulse. After release the block is in FILL with cnt=0.
//  - out_ready while in FILL has no effect.
// TESTING
//  1. Reset, stream 128 beats x[i]=i-64 (s_last on beat 127), out_ready=0.
//     -> out_valid=1 one cycle after beat 127; x[0]=-64, x[127]=63; s_ready=0;
//     x is stable for 20 cycles. Assert out_ready -> next cycle s_ready=1 and all x=0.
//  2. Random s_valid gaps (~50%), data 8'h80..8'h7F.
//     -> x matches the beat order exactly; cnt never skips; no err pulses.
//  3. s_last on beat 9 (data 5 each).
//     -> FULL; x[0..9]=5, x[10..127]=0; err_short pulses once; err_long=0.
//  4. 128 beats with no s_last.
//     -> FULL after beat 127; err_long pulses once.
//     Then send a 129th beat with s_valid=1 -> not accepted (s_ready=0), x unchanged.
//  5. Drop rst_n low asynchronously (between edges) at beat 60, hold 2 cycles,
//     then send a full frame.
//     -> out_valid=0 and x all 0 during reset; new frame lands at x[0..127]; no err pulse.
//  6. Two back-to-back frames with out_ready tied to 1.
//     -> out_valid high exactly 1 cycle per frame; frame 2 starts the cycle after
//     release; 258 cycles total for both frames.

Source files
------------

// File: rtl/fc_in_deserializer.sv
// rtl/fc_in_deserializer.sv - serial activation stream to parallel x[] frame register bank
module fc_in_deserializer #(
    parameter int WIDTH = 8,
    parameter int IN    = 128
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic        [WIDTH-1:0] s_data,
    input  logic                    s_last,
    output logic signed [WIDTH-1:0] x [0:IN-1],
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    err_short,
    output logic                    err_long
);

    localparam int CW = (IN > 1) ? $clog2(IN) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(IN - 1);

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;

    // Frame FSM: fill the bank one beat at a time, then hold it until the consumer releases it.
    // s_ready/out_valid are registered copies of the state so neither has a path from out_ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= FILL;
            cnt       <= '0;
            s_ready   <= 1'b1;
            out_valid <= 1'b0;
            err_short <= 1'b0;
            err_long  <= 1'b0;
            for (int i = 0; i < IN; i++) begin
                x[i] <= '0;
            end
        end else begin
            err_short <= 1'b0;
            err_long  <= 1'b0;
            case (state)
                FILL: begin
                    if (s_valid) begin
                        x[cnt] <= s_data;
                        if ((cnt == LAST_IDX) || s_last) begin
                            // Frame closes either on the last slot or on an early s_last;
                            // slots never written stay at zero from the previous clear.
                            state     <= FULL;
                            cnt       <= '0;
                            s_ready   <= 1'b0;
                            out_valid <= 1'b1;
                            err_long  <= (cnt == LAST_IDX) && !s_last;
                            err_short <= s_last && (cnt != LAST_IDX);
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                FULL: begin
                    if (out_ready) begin
                        state     <= FILL;
                        cnt       <= '0;
                        s_ready   <= 1'b1;
                        out_valid <= 1'b0;
                        for (int i = 0; i < IN; i++) begin
                            x[i] <= '0;
                        end
                    end
                end
                default: begin
                    state     <= FILL;
                    cnt       <= '0;
                    s_ready   <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fc_in_deserializer.sv
// tb/tb_fc_in_deserializer.sv - self-checking bench for fc_in_deserializer
module tb_fc_in_deserializer;

    localparam int WIDTH = 8;
    localparam int IN    = 128;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    s_valid = 1'b0;
    logic                    s_last = 1'b0;
    logic                    out_ready = 1'b0;
    logic        [WIDTH-1:0] s_data = '0;
    logic                    s_ready;
    logic                    out_valid;
    logic                    err_short;
    logic                    err_long;
    logic signed [WIDTH-1:0] x [0:IN-1];

    fc_in_deserializer #(.WIDTH(WIDTH), .IN(IN)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .x(x), .out_valid(out_valid), .out_ready(out_ready),
        .err_short(err_short), .err_long(err_long)
    );

    always #5 clk = ~clk;

    int cmp_n = 0;
    int fail_n = 0;
    int edges = 0;
    int n_short = 0;
    int n_long = 0;
    int n_ovalid = 0;

    // Event counters sampled at the active edge (pre-update values).
    always @(posedge clk) begin
        edges <= edges + 1;
        if (err_short) n_short <= n_short + 1;
        if (err_long)  n_long  <= n_long + 1;
        if (out_valid) n_ovalid <= n_ovalid + 1;
    end

    // Reference: the beats actually handed over, in order.
    logic [WIDTH-1:0] q [$];

    typedef struct {
        int len;
        bit last_end;
        int fixed;      // -1 random, -2 ramp i-64, else constant value
        bit gaps;
        int exp_short;
        int exp_long;
    } vec_t;

    vec_t tbl [6];

    task automatic chk(input string nm, input longint act, input longint exp);
        cmp_n++;
        if (act != exp) begin
            fail_n++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int nonzero_count();
        int n = 0;
        for (int i = 0; i < IN; i++) if (x[i] != '0) n++;
        return n;
    endfunction

    function automatic int frame_diffs();
        int n = 0;
        logic [WIDTH-1:0] e;
        for (int i = 0; i < IN; i++) begin
            e = (i < q.size()) ? q[i] : '0;
            if (x[i] != e) n++;
        end
        return n;
    endfunction

    // Present one beat and return at the falling edge after it was accepted.
    task automatic beat(input logic [WIDTH-1:0] d, input logic l);
        int n = 0;
        while (!s_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("beat_wait_ready", s_ready, 1);
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic send_frame(input int len, input bit last_end, input int fixed, input bit gaps);
        logic [WIDTH-1:0] d;
        int g;
        q.delete();
        for (int i = 0; i < len; i++) begin
            if (fixed == -1)      d = WIDTH'($urandom);
            else if (fixed == -2) d = WIDTH'(i - 64);
            else                  d = WIDTH'(fixed);
            g = 0;
            while (gaps && $urandom_range(1) == 1 && g < 8) begin
                s_data = WIDTH'($urandom);
                s_last = 1'($urandom);
                @(negedge clk);
                g++;
            end
            s_last = 1'b0;
            beat(d, last_end && (i == len - 1));
            q.push_back(d);
        end
    endtask

    task automatic check_frame(input string tag);
        logic [WIDTH-1:0] e;
        chk({tag, "_out_valid"}, out_valid, 1);
        chk({tag, "_s_ready_full"}, s_ready, 0);
        for (int i = 0; i < IN; i++) begin
            e = (i < q.size()) ? q[i] : '0;
            if (x[i] != e) begin
                cmp_n++;
                fail_n++;
                $display("FAIL %s_x[%0d]: got %0d expected %0d", tag, i, x[i], $signed(e));
            end else begin
                cmp_n++;
            end
        end
    endtask

    task automatic release_frame(input string tag);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_rel_s_ready"}, s_ready, 1);
        chk({tag, "_rel_out_valid"}, out_valid, 0);
        chk({tag, "_rel_x_zero"}, nonzero_count(), 0);
    endtask

    initial begin
        int s0, l0, t0, ov0, d;
        tbl[0] = '{128, 1'b1, -2, 1'b0, 0, 0};
        tbl[1] = '{128, 1'b1, -1, 1'b1, 0, 0};
        tbl[2] = '{10,  1'b1,  5, 1'b0, 1, 0};
        tbl[3] = '{128, 1'b0, -1, 1'b0, 0, 1};
        tbl[4] = '{1,   1'b1, -1, 1'b1, 1, 0};
        tbl[5] = '{127, 1'b1, -1, 1'b1, 1, 0};

        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_s_ready", s_ready, 1);
        chk("rst_err_short", err_short, 0);
        chk("rst_err_long", err_long, 0);
        chk("rst_x_zero", nonzero_count(), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int t = 0; t < 6; t++) begin
            s0 = n_short;
            l0 = n_long;
            send_frame(tbl[t].len, tbl[t].last_end, tbl[t].fixed, tbl[t].gaps);
            check_frame($sformatf("v%0d", t));
            if (tbl[t].fixed == -2) begin
                chk("ramp_x0", x[0], -64);
                chk("ramp_x127", x[IN-1], 63);
            end
            // Hold with out_ready low while extra beats are offered: nothing may move.
            d = 0;
            for (int c = 0; c < 20; c++) begin
                s_valid = 1'b1;
                s_data  = WIDTH'($urandom);
                s_last  = 1'($urandom);
                @(negedge clk);
                if (s_ready || !out_valid) d++;
                d += frame_diffs();
            end
            s_valid = 1'b0;
            s_last  = 1'b0;
            chk($sformatf("v%0d_hold_stable", t), d, 0);
            release_frame($sformatf("v%0d", t));
            @(negedge clk);
            chk($sformatf("v%0d_err_short", t), n_short - s0, tbl[t].exp_short);
            chk($sformatf("v%0d_err_long", t), n_long - l0, tbl[t].exp_long);
        end

        // Asynchronous reset mid-frame at beat 60.
        s0 = n_short;
        l0 = n_long;
        for (int i = 0; i < 60; i++) beat(WIDTH'($urandom_range(255, 1)), 1'b0);
        chk("pre_rst_partial", nonzero_count() > 0, 1);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_x_zero", nonzero_count(), 0);
        chk("arst_s_ready", s_ready, 1);
        @(negedge clk);
        @(negedge clk);
        chk("arst_hold_x_zero", nonzero_count(), 0);
        rst_n = 1'b1;
        @(negedge clk);
        send_frame(IN, 1'b1, -1, 1'b1);
        check_frame("post_rst");
        release_frame("post_rst");
        @(negedge clk);
        chk("post_rst_err_short", n_short - s0, 0);
        chk("post_rst_err_long", n_long - l0, 0);

        // Back-to-back frames with the consumer always ready.
        out_ready = 1'b1;
        t0  = edges;
        ov0 = n_ovalid;
        send_frame(IN, 1'b1, -1, 1'b0);
        check_frame("b2b_f1");
        send_frame(IN, 1'b1, -1, 1'b0);
        check_frame("b2b_f2");
        @(negedge clk);
        chk("b2b_cycles", edges - t0, 258);
        chk("b2b_out_valid_low", out_valid, 0);
        @(negedge clk);
        chk("b2b_out_valid_cycles", n_ovalid - ov0, 2);
        out_ready = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, fail_n);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
